// File: rtl/instr_fetch_mem.sv
// Synchronous-read instruction memory for the IF stage, returning FETCH_WIDTH
// consecutive words per fetch, with a ready/valid streaming loader for program fill.
module instr_fetch_mem #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SIZE        = 256,
  parameter int unsigned      FETCH_WIDTH = 1,
  parameter logic [WIDTH-1:0] NOP_INSTR   = 32'h00000013,
  localparam int unsigned     LOGSIZE     = $clog2(SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_start,
  input  logic [LOGSIZE+1:0]           load_base,
  input  logic [WIDTH-1:0]             load_data,
  input  logic                         load_valid,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         load_busy,
  output logic                         load_done,
  output logic                         load_overflow,
  input  logic [31:0]                  pc,
  input  logic                         fetch_en,
  input  logic                         flush,
  output logic [FETCH_WIDTH*WIDTH-1:0] instr_out,
  output logic                         instr_valid,
  output logic                         fetch_fault
);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [WIDTH-1:0]             r_mem [SIZE];
  logic [LOGSIZE-1:0]           r_ptr;
  logic                         r_done;
  logic                         r_overflow;
  logic [FETCH_WIDTH*WIDTH-1:0] r_instr;
  logic                         r_valid;
  logic                         r_fault;

  logic                         w_in_load;
  logic                         w_xfer;
  logic                         w_fault;
  logic [LOGSIZE-1:0]           w_idx;
  logic [FETCH_WIDTH*WIDTH-1:0] w_rd_data;
  logic [FETCH_WIDTH*WIDTH-1:0] w_nop;
  logic [1:0]                   w_unused_base;

  assign w_in_load     = (r_state == S_LOAD);
  assign w_xfer        = w_in_load && load_valid;
  assign w_idx         = pc[LOGSIZE+1:2];
  assign w_nop         = {FETCH_WIDTH{NOP_INSTR}};
  assign w_fault       = (pc[1:0] != 2'b00) || ((pc >> (LOGSIZE + 2)) != 32'd0);
  assign w_unused_base = load_base[1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (load_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_xfer && load_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr      <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= w_xfer && load_last;
      if (!w_in_load && load_start) begin
        r_ptr      <= load_base[LOGSIZE+1:2];
        r_overflow <= 1'b0;
      end else if (w_xfer) begin
        r_ptr <= r_ptr + LOGSIZE'(1);
        if (r_ptr == LOGSIZE'(SIZE - 1) && !load_last) r_overflow <= 1'b1;
      end
    end
  end

  // Memory is deliberately left out of reset; only the write is suppressed in a reset cycle.
  always_ff @(posedge clk) begin
    if (w_xfer && !reset) r_mem[r_ptr] <= load_data;
  end

  // Lane index truncates to LOGSIZE bits so upper lanes wrap to the bottom of memory.
  always_comb begin
    w_rd_data = '0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      w_rd_data[k*WIDTH +: WIDTH] = r_mem[w_idx + LOGSIZE'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush || w_in_load) begin
      r_instr <= w_nop;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (fetch_en) begin
      if (w_fault) begin
        r_instr <= w_nop;
        r_valid <= 1'b0;
        r_fault <= 1'b1;
      end else begin
        r_instr <= w_rd_data;
        r_valid <= 1'b1;
        r_fault <= 1'b0;
      end
    end
  end

  assign load_ready    = w_in_load;
  assign load_busy     = w_in_load;
  assign load_done     = r_done;
  assign load_overflow = r_overflow;
  assign instr_out     = r_instr;
  assign instr_valid   = r_valid;
  assign fetch_fault   = r_fault;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem in dual-issue configuration (FETCH_WIDTH = 2).
module tb_instr_fetch_mem;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [63:0] NOP2 = {NOP, NOP};

  logic        clk = 1'b0;
  logic        reset, load_start, load_valid, load_last;
  logic [9:0]  load_base;
  logic [31:0] load_data;
  logic        load_ready, load_busy, load_done, load_overflow;
  logic [31:0] pc;
  logic        fetch_en, flush;
  logic [63:0] instr_out;
  logic        instr_valid, fetch_fault;

  logic [31:0] mdl [256];
  logic [65:0] sb [$];
  logic [65:0] exp_v;
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .WIDTH(32), .SIZE(256), .FETCH_WIDTH(2), .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_base(load_base), .load_data(load_data),
    .load_valid(load_valid), .load_last(load_last), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done), .load_overflow(load_overflow),
    .pc(pc), .fetch_en(fetch_en), .flush(flush),
    .instr_out(instr_out), .instr_valid(instr_valid), .fetch_fault(fetch_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if ({instr_out, instr_valid, fetch_fault} !== {NOP2, 2'b00}) begin
      errors++; $display("FAIL reset_fetch: got %h/%b/%b want %h/0/0", instr_out, instr_valid, fetch_fault, NOP2);
    end
    vectors++;
    if ({load_ready, load_busy, load_done, load_overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_load: got rdy/busy/done/ovf=%b%b%b%b want 0000", load_ready, load_busy, load_done, load_overflow);
    end
  endtask

  task automatic test_load();
    load_start = 1'b1; load_base = 10'h010; tick(); load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (load_ready !== 1'b1 || load_busy !== 1'b1) begin
        errors++; $display("FAIL load_ready[%0d]: got %b/%b want 1/1", i, load_ready, load_busy);
      end
      load_data = 32'hA0 + 32'(i); load_valid = 1'b1; load_last = (i == 3);
      mdl[4 + i] = load_data;
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    vectors++;
    if ({load_done, load_ready, load_overflow} !== 3'b100) begin
      errors++; $display("FAIL load_done_pulse: got done/rdy/ovf=%b%b%b want 100", load_done, load_ready, load_overflow);
    end
    tick();
    vectors++;
    if (load_done !== 1'b0) begin
      errors++; $display("FAIL load_done_clear: got %b want 0", load_done);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      pc = 32'h10 + 32'(4 * i); fetch_en = 1'b1;
      sb.push_back({mdl[5 + i], mdl[4 + i], 2'b10});
      tick();
      exp_v = sb.pop_front(); vectors++;
      if ({instr_out, instr_valid, fetch_fault} !== exp_v) begin
        errors++; $display("FAIL fetch pc=%h: got %h want %h", pc, {instr_out, instr_valid, fetch_fault}, exp_v);
      end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_stall_flush();
    pc = 32'h10; fetch_en = 1'b1;
    sb.push_back({mdl[5], mdl[4], 2'b10});
    tick(); fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        pc = 32'h100 + 32'(i); sb.push_back({mdl[5], mdl[4], 2'b10}); tick();
      end
      exp_v = sb.pop_front(); vectors++;
      if ({instr_out, instr_valid, fetch_fault} !== exp_v) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, {instr_out, instr_valid, fetch_fault}, exp_v);
      end
    end
    flush = 1'b1; sb.push_back({NOP2, 2'b00}); tick(); flush = 1'b0;
    exp_v = sb.pop_front(); vectors++;
    if ({instr_out, instr_valid, fetch_fault} !== exp_v) begin
      errors++; $display("FAIL flush: got %h want %h", {instr_out, instr_valid, fetch_fault}, exp_v);
    end
  endtask

  task automatic test_fault();
    logic [31:0] bad [3];
    bad[0] = 32'h102; bad[1] = 32'h400; bad[2] = 32'h8000_0010;
    for (int i = 0; i < 3; i++) begin
      pc = bad[i]; fetch_en = 1'b1; sb.push_back({NOP2, 2'b01}); tick();
      exp_v = sb.pop_front(); vectors++;
      if ({instr_out, instr_valid, fetch_fault} !== exp_v) begin
        errors++; $display("FAIL fault pc=%h: got %h want %h", bad[i], {instr_out, instr_valid, fetch_fault}, exp_v);
      end
    end
    fetch_en = 1'b0; pc = 32'h10; sb.push_back({NOP2, 2'b01}); tick();
    exp_v = sb.pop_front(); vectors++;
    if ({instr_out, instr_valid, fetch_fault} !== exp_v) begin
      errors++; $display("FAIL fault_hold: got %h want %h", {instr_out, instr_valid, fetch_fault}, exp_v);
    end
  endtask

  task automatic test_overflow_reset();
    load_start = 1'b1; load_base = 10'h3F8; pc = 32'h14; fetch_en = 1'b1;
    sb.push_back({mdl[6], mdl[5], 2'b10});
    tick(); load_start = 1'b0;
    exp_v = sb.pop_front(); vectors++;
    if ({instr_out, instr_valid, fetch_fault} !== exp_v) begin
      errors++; $display("FAIL start_fetch: got %h want %h", {instr_out, instr_valid, fetch_fault}, exp_v);
    end
    pc = 32'h10;
    for (int i = 0; i < 3; i++) begin
      load_data = 32'hB0 + 32'(i); load_valid = 1'b1; load_last = 1'b0;
      mdl[(254 + i) % 256] = load_data;
      sb.push_back({NOP2, 2'b00});
      tick();
      exp_v = sb.pop_front(); vectors++;
      if ({instr_out, instr_valid, fetch_fault} !== exp_v) begin
        errors++; $display("FAIL load_blocks_fetch[%0d]: got %h want %h", i, {instr_out, instr_valid, fetch_fault}, exp_v);
      end
    end
    load_valid = 1'b0; fetch_en = 1'b0;
    vectors++;
    if ({load_overflow, load_ready} !== 2'b11) begin
      errors++; $display("FAIL overflow_set: got ovf/rdy=%b%b want 11", load_overflow, load_ready);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if ({load_overflow, load_ready, load_busy} !== 3'b000) begin
      errors++; $display("FAIL mid_reset: got ovf/rdy/busy=%b%b%b want 000", load_overflow, load_ready, load_busy);
    end
    load_valid = 1'b1; load_last = 1'b1; load_data = 32'hDEAD_BEEF; tick();
    load_valid = 1'b0; load_last = 1'b0;
    vectors++;
    if ({load_ready, load_done} !== 2'b00) begin
      errors++; $display("FAIL idle_valid_ignored: got rdy/done=%b%b want 00", load_ready, load_done);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [3];
    pcs[0] = 32'h3FC; pcs[1] = 32'h3F8; pcs[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      automatic int unsigned idx = pcs[i][9:2];
      pc = pcs[i]; fetch_en = 1'b1;
      sb.push_back({mdl[(idx + 1) % 256], mdl[idx], 2'b10});
      tick();
      exp_v = sb.pop_front(); vectors++;
      if ({instr_out, instr_valid, fetch_fault} !== exp_v) begin
        errors++; $display("FAIL wrap pc=%h: got %h want %h", pcs[i], {instr_out, instr_valid, fetch_fault}, exp_v);
      end
    end
    fetch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; load_start = 1'b0; load_base = '0; load_data = '0;
    load_valid = 1'b0; load_last = 1'b0; pc = '0; fetch_en = 1'b0; flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_load();
    test_back_to_back();
    test_stall_flush();
    test_fault();
    test_overflow_reset();
    test_wrap();
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
Name: instr_fetch_mem

Overview:
- Parametrised successor to the single-port instruction memory.
- Synchronous-read instruction ROM/RAM feeding the IF stage, returning FETCH_WIDTH consecutive words per fetch (1 = scalar, 2 = dual-issue).
- Adds stall/flush handling, fault detection, and a ready/valid streaming loader FSM with auto-incrementing address for bench or boot-time program fill.

Parameters:
- WIDTH, 32: bits per instruction word.
- SIZE, 256: memory depth in words (power of two); LOGSIZE = $clog2(SIZE).
- FETCH_WIDTH, 1: words returned per fetch (1..4).
- NOP_INSTR, 32'h00000013: bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- load_start  in  1  begin load session (honoured only in IDLE).
- load_base  in  LOGSIZE+2  byte address of first loaded word; bits [1:0] ignored.
- load_data  in  WIDTH  instruction word to write.
- load_valid  in  1  load_data valid.
- load_last  in  1  qualifies final word of session.
- load_ready  out  1  high in LOAD state.
- load_busy  out  1  high in LOAD state.
- load_done  out  1  one-cycle pulse after last word written.
- load_overflow  out  1  sticky; write pointer wrapped during session.
- pc  in  32  byte fetch address.
- fetch_en  in  1  0 = stall, hold outputs.
- flush  in  1  replace next output with bubble.
- instr_out  out  FETCH_WIDTH*WIDTH  lane k in bits [k*WIDTH +: WIDTH], lane 0 = word at pc.
- instr_valid  out  1  instr_out holds a real fetch.
- fetch_fault  out  1  registered fault: misaligned or out-of-range pc.

Behaviour:
- Reset (synchronous): state IDLE, write ptr 0, instr_out all lanes NOP_INSTR, instr_valid 0, fetch_fault 0, load_done 0, load_overflow 0.
  - Memory contents are not cleared.
  - Reset during LOAD abandons the session; words already written remain.
- FSM has two states, IDLE and LOAD.
  - IDLE -> LOAD on load_start: ptr <= load_base[LOGSIZE+1:2], load_overflow <= 0.
  - In LOAD, load_ready = 1; a transfer occurs when load_valid && load_ready.
  - Each transfer writes mem[ptr] <= load_data, then ptr <= ptr+1 mod SIZE.
  - A transfer at ptr == SIZE-1 without load_last wraps ptr to 0 and sets load_overflow.
  - A transfer with load_last -> IDLE; load_done pulses high the following cycle.
  - load_start during LOAD is ignored.
  - load_valid or load_last while in IDLE is ignored (no write).
- Fetch is registered with 1-cycle latency. Priority each cycle is reset > flush > LOAD state > fault > fetch_en.
  - flush: instr_out <= all NOP_INSTR, instr_valid <= 0, fetch_fault <= 0. Applies even if fetch_en = 0.
  - LOAD state: instr_out <= NOP_INSTR, instr_valid <= 0, fetch_fault <= 0. Fetches are blocked.
  - Fault: fetch_en && (pc[1:0] != 0 || pc[31:LOGSIZE+2] != 0). Result: instr_out <= NOP_INSTR, instr_valid <= 0, fetch_fault <= 1.
  - Normal fetch, fetch_en && no fault: with idx = pc[LOGSIZE+1:2], lane k <= mem[(idx+k) mod SIZE], instr_valid <= 1, fetch_fault <= 0.
  - Lanes wrap modulo SIZE at the top of memory; no fault is raised for wrapped lanes.
  - fetch_en = 0: instr_out, instr_valid and fetch_fault hold their previous values.
- load_start and a fetch in the same IDLE cycle: the fetch completes normally; LOAD begins the next cycle.
- Read-during-write cannot occur, because fetch is blocked in LOAD.

Test Plan:
- Load 4 words (0xA0..0xA3) at load_base 0x10, load_valid held high, load_last on the 4th:
  - load_ready high for 4 cycles; load_done pulses 1 cycle after the 4th transfer.
  - A subsequent fetch at pc 0x10 returns 0xA0 one cycle later with instr_valid = 1.
- FETCH_WIDTH = 2, pc = 0x3FC (SIZE = 256):
  - instr_out = {mem[0], mem[255]}, instr_valid = 1, fetch_fault = 0.
- pc = 0x102:
  - fetch_fault = 1, instr_valid = 0, instr_out = 0x00000013.
- pc = 0x400:
  - same fault response as the misaligned case.
- fetch at pc 0x10 -> 0xA0; then fetch_en = 0 for 3 cycles with pc changing:
  - instr_out stays 0xA0, instr_valid stays 1.
  - flush (with fetch_en = 0) -> next cycle instr_out = NOP, instr_valid = 0.
- Load 3 words at load_base 0x3F8 without load_last:
  - Words land at 254, 255, 0; load_overflow = 1.
  - Fetch attempts during LOAD give instr_valid = 0.
  - Assert reset mid-session: state IDLE, load_ready = 0, load_overflow = 0, written words retained.
